spi_slave_endpoint: RTL and testbench

Synchronous SPI slave that sits on the far end of the SPI master's serial pins and consumes `sclk`/`mosi`/`cs` while producing `miso`. It runs entirely in the `clk_i` domain and oversamples the serial lines. It delivers each received byte on a one-cycle valid strobe and serializes the byte held in a one-entry transmit buffer. It serves as the in-fabric loopback partner for master regression and as the slave front end in integrated designs.

---
 rtl/spi_slave_endpoint_if.sv | 37 +++
 rtl/spi_slave_endpoint.sv | 199 +++++++++++++++++++
 tb/tb_spi_slave_endpoint.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_endpoint_if.sv
// spi_slave_endpoint_if: groups the serial pins and the parallel transmit/receive
// handshake of the SPI slave endpoint.
//   slave modport  : the endpoint's view (serial pins and tx handshake in; miso, rx data, status out)
//   master modport : the view of whatever drives the endpoint (SPI master plus local tx/rx user)
// Signals:
//   sclk_i, mosi_i, cs_i  serial clock, data and active-low select from the SPI master
//   miso_o, miso_oe_o     serial data back to the master and its output enable
//   tx_data_i, tx_load_i  byte to send and its write strobe; tx_ready_o flags an empty buffer
//   rx_data_o, rx_valid_o last received byte and its one-cycle strobe
//   busy_o                high while selected
//   tx_underrun_o         one-cycle strobe: a frame started with an empty buffer
interface spi_slave_endpoint_if #(
    parameter int DATA_W = 8
);
    logic              sclk_i;
    logic              mosi_i;
    logic              cs_i;
    logic              miso_o;
    logic              miso_oe_o;
    logic [DATA_W-1:0] tx_data_i;
    logic              tx_load_i;
    logic              tx_ready_o;
    logic [DATA_W-1:0] rx_data_o;
    logic              rx_valid_o;
    logic              busy_o;
    logic              tx_underrun_o;

    modport slave (
        input  sclk_i, mosi_i, cs_i, tx_data_i, tx_load_i,
        output miso_o, miso_oe_o, tx_ready_o, rx_data_o, rx_valid_o, busy_o, tx_underrun_o
    );

    modport master (
        output sclk_i, mosi_i, cs_i, tx_data_i, tx_load_i,
        input  miso_o, miso_oe_o, tx_ready_o, rx_data_o, rx_valid_o, busy_o, tx_underrun_o
    );
endinterface

// File: rtl/spi_slave_endpoint.sv
// spi_slave_endpoint: oversampling SPI mode-0 slave running entirely in the clk_i domain.
// Received bytes are delivered on a one-cycle rx_valid_o strobe; the byte held in a
// one-entry transmit buffer is shifted out MSB first on miso_o.
// Ports:
//   clk_i   system clock, rising edge
//   arst_i  asynchronous active-high reset
//   bus     spi_slave_endpoint_if.slave (serial pins, tx handshake, rx data, status)
module spi_slave_endpoint #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic                 clk_i,
    input logic                 arst_i,
    spi_slave_endpoint_if.slave bus
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sclk_d;
    logic                   mosi_d;
    logic                   cs_d;
    logic                   sclk_rise;
    logic                   sclk_fall;

    logic                   load_now;
    logic                   rise_now;
    logic                   fall_now;
    logic                   last_rise;

    logic [DATA_W-1:0]      tx_buf;
    logic                   tx_ready;
    logic [DATA_W-1:0]      tx_shift;
    logic [DATA_W-1:0]      rx_shift;
    logic [DATA_W-1:0]      rx_data;
    logic                   rx_valid;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   frame_done;
    logic                   miso;
    logic                   miso_oe;
    logic                   busy;
    logic                   tx_underrun;

    // Pin synchronizers, one delay flop per line, and registered sclk edge pulses.
    // mosi_d and cs_d are captured on the same edge as the pulses, so a pulse and
    // the mosi/cs level it belongs to are visible in the same cycle.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
            sclk_d    <= 1'b0;
            mosi_d    <= 1'b0;
            cs_d      <= 1'b1;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi_i};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs_i};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            mosi_d    <= mosi_sync[SYNC_STAGES-1];
            cs_d      <= cs_sync[SYNC_STAGES-1];
            sclk_rise <= sclk_sync[SYNC_STAGES-1] & ~sclk_d;
            sclk_fall <= ~sclk_sync[SYNC_STAGES-1] & sclk_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and per-cycle datapath strobes; deselect overrides everything.
    always_comb begin
        state_next = state;
        load_now   = 1'b0;
        rise_now   = 1'b0;
        fall_now   = 1'b0;
        if (cs_d) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_next = LOAD;
                end
                LOAD: begin
                    load_now   = 1'b1;
                    state_next = SHIFT;
                end
                SHIFT: begin
                    rise_now = sclk_rise;
                    fall_now = sclk_fall;
                    // The falling edge after the last bit closes the frame and
                    // reloads for a possible back-to-back byte.
                    if (sclk_fall && frame_done) begin
                        state_next = LOAD;
                    end else begin
                        state_next = SHIFT;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
        last_rise = rise_now && (bit_cnt == CNT_W'(DATA_W - 1));
    end

    // One-entry transmit buffer. tx_ready low means the buffer holds a byte; a
    // load is only accepted while empty, and LOAD only consumes while full, so
    // the two never collide.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            tx_buf   <= '0;
            tx_ready <= 1'b1;
        end else if (bus.tx_load_i && tx_ready) begin
            tx_buf   <= bus.tx_data_i;
            tx_ready <= 1'b0;
        end else if (load_now && !tx_ready) begin
            tx_ready <= 1'b1;
        end
    end

    // Shift registers, bit counter and serial output.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            tx_shift   <= '0;
            rx_shift   <= '0;
            rx_data    <= '0;
            bit_cnt    <= '0;
            frame_done <= 1'b0;
            miso       <= 1'b0;
        end else if (state_next == IDLE) begin
            // Idle or deselected: any partial frame is abandoned.
            tx_shift   <= '0;
            rx_shift   <= '0;
            bit_cnt    <= '0;
            frame_done <= 1'b0;
            miso       <= 1'b0;
        end else if (load_now) begin
            tx_shift   <= tx_ready ? '0 : tx_buf;
            miso       <= tx_ready ? 1'b0 : tx_buf[DATA_W-1];
            bit_cnt    <= '0;
            frame_done <= 1'b0;
        end else if (rise_now) begin
            rx_shift <= {rx_shift[DATA_W-2:0], mosi_d};
            if (last_rise) begin
                rx_data    <= {rx_shift[DATA_W-2:0], mosi_d};
                bit_cnt    <= '0;
                frame_done <= 1'b1;
            end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end else if (fall_now && !frame_done) begin
            // The falling edge after the last bit is left to LOAD, so miso holds
            // the last bit until the next frame's MSB is ready.
            tx_shift <= tx_shift << 1;
            miso     <= tx_shift[DATA_W-2];
        end
    end

    // Registered status strobes and enables.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            busy        <= 1'b0;
            miso_oe     <= 1'b0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            busy        <= (state_next != IDLE);
            miso_oe     <= (state_next != IDLE);
            rx_valid    <= last_rise;
            tx_underrun <= load_now && tx_ready;
        end
    end

    assign bus.miso_o        = miso;
    assign bus.miso_oe_o     = miso_oe;
    assign bus.tx_ready_o    = tx_ready;
    assign bus.rx_data_o     = rx_data;
    assign bus.rx_valid_o    = rx_valid;
    assign bus.busy_o        = busy;
    assign bus.tx_underrun_o = tx_underrun;
endmodule

// File: tb/tb_spi_slave_endpoint.sv
// tb_spi_slave_endpoint: drives the endpoint as a mode-0 SPI master with a
// half-period of HP clk_i cycles, checks a table of single frames, a few
// hand-written corner sequences, and randomized selects against a byte-level
// reference model (buffer full flag, byte queues, underrun count).
module tb_spi_slave_endpoint;
    localparam int DW = 8;
    localparam int SS = 2;
    localparam int HP = 8;

    logic clk_i  = 1'b0;
    logic arst_i = 1'b1;

    spi_slave_endpoint_if #(.DATA_W(DW)) bus ();

    spi_slave_endpoint #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .bus    (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    int         rx_pulses = 0;
    int         urun_pulses = 0;
    logic [7:0] rx_got[$];

    // Monitor: record every rx strobe cycle and every underrun strobe cycle.
    always @(negedge clk_i) begin
        if (bus.rx_valid_o) begin
            rx_pulses <= rx_pulses + 1;
            rx_got.push_back(bus.rx_data_o);
        end
        if (bus.tx_underrun_o) begin
            urun_pulses <= urun_pulses + 1;
        end
    end

    // Reference model state.
    logic       m_full = 1'b0;
    logic [7:0] m_buf  = 8'h00;
    int         m_urun = 0;
    logic [7:0] m_rx[$];

    // Per-select stimulus and results.
    logic [7:0] mo[4];
    logic       ml_en[4];
    logic [7:0] ml_val[4];
    logic [7:0] mi_got[4];
    logic [7:0] exp_mi[4];

    typedef struct {
        logic       pre_en;
        logic [7:0] pre_val;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
        int         exp_urun;
    } vec_t;

    vec_t vt[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // One-cycle load strobe; the model accepts it only when its buffer is empty.
    task automatic tb_load(input logic [7:0] v);
        bus.tx_data_i = v;
        bus.tx_load_i = 1'b1;
        if (!m_full) begin
            m_buf  = v;
            m_full = 1'b1;
        end
        @(negedge clk_i);
        bus.tx_load_i = 1'b0;
    endtask

    task automatic clear_ml();
        for (int b = 0; b < 4; b++) begin
            ml_en[b]  = 1'b0;
            ml_val[b] = 8'h00;
        end
    endtask

    // One select of nb bytes, or of abort_bits bits when abort_bits > 0.
    // The final sclk fall and cs release happen together.
    task automatic run_select(input int nb, input int abort_bits);
        int total;
        total = (abort_bits > 0) ? abort_bits : nb * 8;
        bus.cs_i = 1'b0;
        wait_cyc(HP);
        for (int k = 0; k < total; k++) begin
            int byt;
            int bi;
            byt = k / 8;
            bi  = 7 - (k % 8);
            if (bi == 7) begin
                exp_mi[byt] = m_full ? m_buf : 8'h00;
                if (!m_full) m_urun++;
                m_full = 1'b0;
            end
            bus.mosi_i = mo[byt][bi];
            if (bi == 3 && ml_en[byt]) begin
                tb_load(ml_val[byt]);
                wait_cyc(HP - 1);
            end else begin
                wait_cyc(HP);
            end
            if (k == 0) begin
                chk("busy_sel", {31'd0, bus.busy_o}, 32'd1);
                chk("oe_sel", {31'd0, bus.miso_oe_o}, 32'd1);
            end
            mi_got[byt][bi] = bus.miso_o;
            bus.sclk_i = 1'b1;
            wait_cyc(HP);
            bus.sclk_i = 1'b0;
            if (k == total - 1) bus.cs_i = 1'b1;
        end
        if (abort_bits == 0) begin
            for (int b = 0; b < nb; b++) m_rx.push_back(mo[b]);
        end
        wait_cyc(12);
    endtask

    task automatic check_rx();
        chk("rx_count", rx_got.size(), m_rx.size());
        while (rx_got.size() > 0 && m_rx.size() > 0) begin
            logic [7:0] a;
            logic [7:0] e;
            a = rx_got.pop_front();
            e = m_rx.pop_front();
            chk("rx_byte", {24'd0, a}, {24'd0, e});
        end
        rx_got.delete();
        m_rx.delete();
    endtask

    initial begin
        int u0;
        int r0;
        int mu0;

        vt[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 0};
        vt[1] = '{1'b0, 8'h00, 8'hFF, 8'h00, 8'hFF, 1};
        vt[2] = '{1'b1, 8'h81, 8'h00, 8'h81, 8'h00, 0};
        vt[3] = '{1'b1, 8'hFF, 8'h5A, 8'hFF, 8'h5A, 0};

        bus.sclk_i    = 1'b0;
        bus.mosi_i    = 1'b0;
        bus.cs_i      = 1'b1;
        bus.tx_data_i = 8'h00;
        bus.tx_load_i = 1'b0;
        clear_ml();

        // Reset state with pins idle.
        wait_cyc(3);
        chk("rst_miso", {31'd0, bus.miso_o}, 32'd0);
        chk("rst_oe", {31'd0, bus.miso_oe_o}, 32'd0);
        chk("rst_rx_data", {24'd0, bus.rx_data_o}, 32'd0);
        chk("rst_rx_valid", {31'd0, bus.rx_valid_o}, 32'd0);
        chk("rst_tx_ready", {31'd0, bus.tx_ready_o}, 32'd1);
        chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("rst_underrun", {31'd0, bus.tx_underrun_o}, 32'd0);
        arst_i = 1'b0;
        wait_cyc(4);

        // Table of single frames.
        for (int i = 0; i < 4; i++) begin
            clear_ml();
            rx_got.delete();
            m_rx.delete();
            if (vt[i].pre_en) tb_load(vt[i].pre_val);
            wait_cyc(2);
            mo[0] = vt[i].mosi;
            u0 = urun_pulses;
            r0 = rx_pulses;
            run_select(1, 0);
            chk("vec_miso", {24'd0, mi_got[0]}, {24'd0, vt[i].exp_miso});
            chk("vec_rx_pulses", rx_pulses - r0, 32'd1);
            chk("vec_rx_data", {24'd0, rx_got[0]}, {24'd0, vt[i].exp_rx});
            chk("vec_underrun", urun_pulses - u0, vt[i].exp_urun);
            chk("vec_tx_ready", {31'd0, bus.tx_ready_o}, 32'd1);
            chk("vec_busy_idle", {31'd0, bus.busy_o}, 32'd0);
            chk("vec_oe_idle", {31'd0, bus.miso_oe_o}, 32'd0);
        end
        rx_got.delete();
        m_rx.delete();

        // Back-to-back bytes: 0x11 preloaded, 0x22 loaded during byte 1.
        clear_ml();
        tb_load(8'h11);
        wait_cyc(2);
        mo[0] = 8'h12;
        mo[1] = 8'h34;
        ml_en[0]  = 1'b1;
        ml_val[0] = 8'h22;
        u0 = urun_pulses;
        r0 = rx_pulses;
        run_select(2, 0);
        chk("b2b_miso0", {24'd0, mi_got[0]}, 32'h11);
        chk("b2b_miso1", {24'd0, mi_got[1]}, 32'h22);
        chk("b2b_rx_pulses", rx_pulses - r0, 32'd2);
        chk("b2b_rx0", {24'd0, rx_got[0]}, 32'h12);
        chk("b2b_rx1", {24'd0, rx_got[1]}, 32'h34);
        chk("b2b_underrun", urun_pulses - u0, 32'd0);
        rx_got.delete();
        m_rx.delete();

        // Deselect after 5 bits, then a full frame.
        clear_ml();
        tb_load(8'hC3);
        mo[0] = 8'h96;
        r0 = rx_pulses;
        run_select(1, 5);
        chk("abort_rx_pulses", rx_pulses - r0, 32'd0);
        chk("abort_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("abort_oe", {31'd0, bus.miso_oe_o}, 32'd0);
        chk("abort_miso", {31'd0, bus.miso_o}, 32'd0);
        chk("abort_tx_ready", {31'd0, bus.tx_ready_o}, 32'd1);
        tb_load(8'h5E);
        mo[0] = 8'h24;
        r0 = rx_pulses;
        run_select(1, 0);
        chk("post_abort_miso", {24'd0, mi_got[0]}, 32'h5E);
        chk("post_abort_pulses", rx_pulses - r0, 32'd1);
        chk("post_abort_rx", {24'd0, bus.rx_data_o}, 32'h24);
        rx_got.delete();
        m_rx.delete();

        // A load while the buffer is full is ignored.
        tb_load(8'h77);
        chk("ready_full", {31'd0, bus.tx_ready_o}, 32'd0);
        tb_load(8'h99);
        wait_cyc(2);
        mo[0] = 8'h6D;
        run_select(1, 0);
        chk("ignored_load_miso", {24'd0, mi_got[0]}, 32'h77);
        chk("ignored_load_ready", {31'd0, bus.tx_ready_o}, 32'd1);
        rx_got.delete();
        m_rx.delete();

        // Asynchronous reset in the middle of a frame.
        tb_load(8'h4B);
        bus.cs_i = 1'b0;
        wait_cyc(HP);
        for (int k = 0; k < 3; k++) begin
            bus.mosi_i = 1'b1;
            wait_cyc(HP);
            bus.sclk_i = 1'b1;
            wait_cyc(HP);
            bus.sclk_i = 1'b0;
        end
        bus.sclk_i = 1'b1;
        wait_cyc(2);
        #2 arst_i = 1'b1;
        #1;
        chk("arst_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("arst_oe", {31'd0, bus.miso_oe_o}, 32'd0);
        chk("arst_miso", {31'd0, bus.miso_o}, 32'd0);
        chk("arst_tx_ready", {31'd0, bus.tx_ready_o}, 32'd1);
        chk("arst_rx_data", {24'd0, bus.rx_data_o}, 32'd0);
        chk("arst_rx_valid", {31'd0, bus.rx_valid_o}, 32'd0);
        bus.sclk_i = 1'b0;
        bus.cs_i   = 1'b1;
        bus.mosi_i = 1'b0;
        @(negedge clk_i);
        arst_i = 1'b0;
        m_full = 1'b0;
        rx_got.delete();
        m_rx.delete();
        wait_cyc(4);
        tb_load(8'hE7);
        mo[0] = 8'h81;
        u0 = urun_pulses;
        run_select(1, 0);
        chk("post_rst_miso", {24'd0, mi_got[0]}, 32'hE7);
        chk("post_rst_underrun", urun_pulses - u0, 32'd0);
        check_rx();

        // Randomized selects against the reference model.
        for (int it = 0; it < 20; it++) begin
            int nb;
            nb = $urandom_range(1, 3);
            clear_ml();
            if ($urandom_range(0, 1) == 1) tb_load(8'($urandom));
            wait_cyc(2);
            for (int b = 0; b < 4; b++) begin
                mo[b]     = 8'($urandom);
                ml_en[b]  = ($urandom_range(0, 1) == 1);
                ml_val[b] = 8'($urandom);
            end
            u0  = urun_pulses;
            mu0 = m_urun;
            run_select(nb, 0);
            for (int b = 0; b < nb; b++) begin
                chk("rnd_miso", {24'd0, mi_got[b]}, {24'd0, exp_mi[b]});
            end
            check_rx();
            chk("rnd_underrun", urun_pulses - u0, m_urun - mu0);
            chk("rnd_tx_ready", {31'd0, bus.tx_ready_o}, {31'd0, !m_full});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
